// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants for the MIPS pipeline.
// The fetch entry layout grows a misalign flag when IFU_MISALIGN_CHECK_EN is defined.
package mips_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h00000000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h00000000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
`ifdef IFU_MISALIGN_CHECK_EN
        logic            misalign;
`endif
    } fetch_entry_t;

    // PC arithmetic wraps modulo 2^32 by construction of the 32-bit add.
    function automatic logic [XLEN-1:0] pcPlus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifu_prefetch_queue.sv
// Circular-buffer prefetch FIFO holding fetched {pc, instr} entries.
// Supports simultaneous push/pop when full, and a flush that empties it in one edge.
module ifu_prefetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push_i) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (pop_i)  rdPtr_d = rdPtr_q + PTR_W'(1);
            if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
            else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the count masks stale entries.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wrPtr_q] <= data_i;
    end

    assign head_o  = mem_q[rdPtr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner: drives the instruction ROM, fills the prefetch queue, handles redirects.
// Optional misaligned-PC flagging is enabled by defining IFU_MISALIGN_CHECK_EN.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_misalign
);

    logic [XLEN-1:0] fetchPc_q, fetchPc_d;
    logic            qFlush, qPush, qPop;
    logic            qFull, qEmpty;
    fetch_entry_t    pushEntry, headEntry;

    // A redirect outranks the handshake: the head is dropped even if decode was ready.
    always_comb begin
        fetchPc_d = fetchPc_q;
        qFlush    = 1'b0;
        qPush     = 1'b0;
        qPop      = 1'b0;
        if (redirect_valid) begin
            qFlush    = 1'b1;
            fetchPc_d = redirect_pc;
        end else begin
            qPop  = !qEmpty && id_ready;
            qPush = !qFull || qPop;
            if (qPush) fetchPc_d = pcPlus4(fetchPc_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fetchPc_q <= RESET_PC;
        else       fetchPc_q <= fetchPc_d;
    end

    always_comb begin
        pushEntry       = '0;
        pushEntry.pc    = fetchPc_q;
        pushEntry.instr = imem_instr;
`ifdef IFU_MISALIGN_CHECK_EN
        pushEntry.misalign = |fetchPc_q[1:0];
`endif
    end

    ifu_prefetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .flush_i (qFlush),
        .push_i  (qPush),
        .pop_i   (qPop),
        .data_i  (pushEntry),
        .head_o  (headEntry),
        .full_o  (qFull),
        .empty_o (qEmpty)
    );

    assign imem_addr   = fetchPc_q;
    assign if_valid    = !qEmpty;
    assign if_instr    = qEmpty ? NOP_INSTR : headEntry.instr;
    assign if_pc       = qEmpty ? '0 : headEntry.pc;
    assign if_pc_plus4 = qEmpty ? '0 : pcPlus4(headEntry.pc);
`ifdef IFU_MISALIGN_CHECK_EN
    assign if_misalign = !qEmpty && headEntry.misalign;
`else
    assign if_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit against a queue-based fetch model.
// Misalign checks are compiled in when IFU_MISALIGN_CHECK_EN is defined.
module tb_instruction_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h00000000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        id_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_misalign;

    logic [31:0] rom [256];
    logic [31:0] mPc;
    ent_t        mq[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    assign imem_instr = rom[imem_addr[9:2]];

    instruction_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_misalign    (if_misalign)
    );

    function automatic logic expValid();
        return mq.size() != 0;
    endfunction

    function automatic logic [31:0] expPc();
        return (mq.size() != 0) ? mq[0].pc : 32'h0;
    endfunction

    function automatic logic [31:0] expInstr();
        return (mq.size() != 0) ? mq[0].instr : 32'h0;
    endfunction

    function automatic logic [31:0] expPlus4();
        return (mq.size() != 0) ? mq[0].pc + 32'd4 : 32'h0;
    endfunction

    function automatic logic expMisalign();
        logic [31:0] p;
        p = expPc();
`ifdef IFU_MISALIGN_CHECK_EN
        return (mq.size() != 0) && (p[1:0] != 2'b00);
`else
        return 1'b0 & p[0];
`endif
    endfunction

    task automatic modelReset();
        mPc = RESET_PC;
        mq.delete();
    endtask

    task automatic resetDut();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    // Drive one cycle of inputs, advance the model across the edge, sample 1 time unit later.
    task automatic advance(input logic rv, input logic [31:0] rpc, input logic rdy);
        int   n;
        logic deq;
        ent_t e;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        if (rv) begin
            mq.delete();
            mPc = rpc;
        end else begin
            n   = mq.size();
            deq = (n > 0) && rdy;
            if (deq) void'(mq.pop_front());
            if (n < DEPTH || deq) begin
                e.pc    = mPc;
                e.instr = rom[mPc[9:2]];
                mq.push_back(e);
                mPc = mPc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        vectors++;
        if (if_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_valid: got %b expected 0", if_valid);
        end
        vectors++;
        if (if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_head: got instr %h pc %h pc4 %h expected all 0", if_instr, if_pc, if_pc_plus4);
        end
        vectors++;
        if (imem_addr !== RESET_PC || if_misalign !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_addr: got addr %h mis %b expected %h 0", imem_addr, if_misalign, RESET_PC);
        end
    endtask

    task automatic test_basic();
        resetDut();
        advance(1'b0, 32'h0, 1'b1);
        vectors++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h20080001) begin
            miscompares++;
            $display("[TB] FAIL basic_first: got v %b pc %h instr %h expected 1 0 20080001", if_valid, if_pc, if_instr);
        end
        advance(1'b0, 32'h0, 1'b1);
        vectors++;
        if (if_pc !== 32'h4 || if_instr !== 32'h200a0001 || if_pc_plus4 !== 32'h8) begin
            miscompares++;
            $display("[TB] FAIL basic_second: got pc %h instr %h pc4 %h expected 4 200a0001 8", if_pc, if_instr, if_pc_plus4);
        end
    endtask

    task automatic test_stall();
        logic [31:0] want;
        resetDut();
        for (int i = 0; i < 5; i++) advance(1'b0, 32'h0, 1'b0);
        vectors++;
        if (imem_addr !== 32'h8 || if_pc !== 32'h0 || if_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stall_hold: got addr %h pc %h v %b expected 8 0 1", imem_addr, if_pc, if_valid);
        end
        for (int i = 1; i <= 2; i++) begin
            advance(1'b0, 32'h0, 1'b1);
            want = 32'(i * 4);
            vectors++;
            if (if_valid !== 1'b1 || if_pc !== want || if_instr !== rom[i]) begin
                miscompares++;
                $display("[TB] FAIL stall_release: got v %b pc %h instr %h expected 1 %h %h", if_valid, if_pc, if_instr, want, rom[i]);
            end
        end
    endtask

    task automatic test_redirect();
        resetDut();
        advance(1'b0, 32'h0, 1'b1);
        advance(1'b0, 32'h0, 1'b0);
        advance(1'b1, 32'h0000001C, 1'b1);
        vectors++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h1C) begin
            miscompares++;
            $display("[TB] FAIL redirect_n1: got v %b addr %h expected 0 1c", if_valid, imem_addr);
        end
        advance(1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_valid !== 1'b1 || if_pc !== 32'h1C || if_instr !== rom[7]) begin
            miscompares++;
            $display("[TB] FAIL redirect_n2: got v %b pc %h instr %h expected 1 1c %h", if_valid, if_pc, if_instr, rom[7]);
        end
    endtask

    task automatic test_redirect_full();
        resetDut();
        for (int i = 0; i < 3; i++) advance(1'b0, 32'h0, 1'b0);
        advance(1'b1, 32'h00000040, 1'b1);
        vectors++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h40) begin
            miscompares++;
            $display("[TB] FAIL redirect_full_flush: got v %b addr %h expected 0 40", if_valid, imem_addr);
        end
        advance(1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_pc !== 32'h40 || if_instr !== rom[16] || imem_addr !== 32'h44) begin
            miscompares++;
            $display("[TB] FAIL redirect_full_resume: got pc %h instr %h addr %h expected 40 %h 44", if_pc, if_instr, imem_addr, rom[16]);
        end
    endtask

    task automatic test_wrap();
        resetDut();
        advance(1'b1, 32'hFFFFFFFC, 1'b0);
        advance(1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_pc !== 32'hFFFFFFFC || if_pc_plus4 !== 32'h0 || imem_addr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL wrap_plus4: got pc %h pc4 %h addr %h expected fffffffc 0 0", if_pc, if_pc_plus4, imem_addr);
        end
        advance(1'b0, 32'h0, 1'b1);
        vectors++;
        if (if_pc !== 32'h0 || if_instr !== rom[0]) begin
            miscompares++;
            $display("[TB] FAIL wrap_next: got pc %h instr %h expected 0 %h", if_pc, if_instr, rom[0]);
        end
    endtask

    task automatic test_async_reset();
        resetDut();
        for (int i = 0; i < 3; i++) advance(1'b0, 32'h0, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || if_pc_plus4 !== 32'h0 || imem_addr !== RESET_PC) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got v %b pc %h instr %h pc4 %h addr %h expected all 0", if_valid, if_pc, if_instr, if_pc_plus4, imem_addr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

`ifdef IFU_MISALIGN_CHECK_EN
    task automatic test_misalign();
        resetDut();
        advance(1'b1, 32'h00000006, 1'b0);
        advance(1'b0, 32'h0, 1'b0);
        vectors++;
        if (if_misalign !== 1'b1 || if_pc !== 32'h6 || if_instr !== rom[1]) begin
            miscompares++;
            $display("[TB] FAIL misalign_head: got mis %b pc %h instr %h expected 1 6 %h", if_misalign, if_pc, if_instr, rom[1]);
        end
        advance(1'b0, 32'h0, 1'b0);
        advance(1'b0, 32'h0, 1'b1);
        vectors++;
        if (if_misalign !== 1'b1 || if_pc !== 32'hA || if_instr !== rom[2]) begin
            miscompares++;
            $display("[TB] FAIL misalign_seq: got mis %b pc %h instr %h expected 1 a %h", if_misalign, if_pc, if_instr, rom[2]);
        end
    endtask
`endif

    task automatic test_random();
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic [31:0] mask;
`ifdef IFU_MISALIGN_CHECK_EN
        mask = 32'h000003FF;
`else
        mask = 32'h000003FC;
`endif
        resetDut();
        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            rpc = ($urandom_range(0, 4) == 0) ? (32'hFFFFFFF0 | ($urandom & mask & 32'hF)) : ($urandom & mask);
            advance(rv, rpc, rdy);
            vectors++;
            if (if_valid !== expValid()) begin
                miscompares++;
                $display("[TB] FAIL rand_valid cyc %0d: got %b expected %b", i, if_valid, expValid());
            end
            vectors++;
            if (if_pc !== expPc() || if_instr !== expInstr()) begin
                miscompares++;
                $display("[TB] FAIL rand_head cyc %0d: got pc %h instr %h expected %h %h", i, if_pc, if_instr, expPc(), expInstr());
            end
            vectors++;
            if (if_pc_plus4 !== expPlus4()) begin
                miscompares++;
                $display("[TB] FAIL rand_plus4 cyc %0d: got %h expected %h", i, if_pc_plus4, expPlus4());
            end
            vectors++;
            if (imem_addr !== mPc) begin
                miscompares++;
                $display("[TB] FAIL rand_addr cyc %0d: got %h expected %h", i, imem_addr, mPc);
            end
            vectors++;
            if (if_misalign !== expMisalign()) begin
                miscompares++;
                $display("[TB] FAIL rand_misalign cyc %0d: got %b expected %b", i, if_misalign, expMisalign());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[0] = 32'h20080001;
        rom[1] = 32'h200a0001;
        modelReset();
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_redirect_full();
        test_wrap();
        test_async_reset();
`ifdef IFU_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
